// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a parallel word out MSB-first, optionally repeated,
// and counts overlapping "1011" occurrences in the emitted stream. Optional macro: SEQ_TX_GAP_EN.
module seq_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [REP_W-1:0] in_repeat,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt,
  input  logic             clear_cnt
);

  localparam int IDX_W = $clog2(WIDTH);

`ifdef SEQ_TX_GAP_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
`else
  typedef enum logic {S_IDLE, S_SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [REP_W-1:0] rep_left_q, rep_left_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [3:0]       hist_q, hist_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [3:0]       hist_next;

  assign in_ready  = (state_q == S_IDLE);
  assign x         = x_q;
  assign x_valid   = x_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign match_cnt = match_cnt_q;
  assign hist_next = {hist_q[2:0], x_d};

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    rep_left_d  = rep_left_q;
    x_d         = 1'b0;
    x_valid_d   = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    hist_d      = hist_q;
    match_cnt_d = match_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          hold_d     = in_data;
          shift_d    = in_data << 1;
          bit_idx_d  = IDX_W'(WIDTH - 1);
          rep_left_d = in_repeat;
          x_d        = in_data[WIDTH-1];
          x_valid_d  = 1'b1;
          busy_d     = 1'b1;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // bit_idx counts the bits of the current word still to come after the one on x.
        if (bit_idx_q != '0) begin
          x_d       = shift_q[WIDTH-1];
          x_valid_d = 1'b1;
          shift_d   = shift_q << 1;
          bit_idx_d = bit_idx_q - 1'b1;
        end else if (rep_left_q != '0) begin
          rep_left_d = rep_left_q - 1'b1;
`ifdef SEQ_TX_GAP_EN
          state_d    = S_GAP;
`else
          x_d        = hold_q[WIDTH-1];
          x_valid_d  = 1'b1;
          shift_d    = hold_q << 1;
          bit_idx_d  = IDX_W'(WIDTH - 1);
`endif
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
`ifdef SEQ_TX_GAP_EN
      S_GAP: begin
        x_d       = hold_q[WIDTH-1];
        x_valid_d = 1'b1;
        shift_d   = hold_q << 1;
        bit_idx_d = IDX_W'(WIDTH - 1);
        state_d   = S_SHIFT;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // The count reflects the bit being launched on this edge, so it lines up with x.
    if (x_valid_d) begin
      hist_d = hist_next;
      if (hist_next == 4'b1011 && !(&match_cnt_q))
        match_cnt_d = match_cnt_q + 1'b1;
    end
    if (clear_cnt) begin
      hist_d      = '0;
      match_cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rep_left_q  <= '0;
      bit_idx_q   <= '0;
      x_q         <= 1'b0;
      x_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hist_q      <= '0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rep_left_q  <= rep_left_d;
      bit_idx_q   <= bit_idx_d;
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      hist_q      <= hist_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  // NOTE: word registers carry no reset; they are always loaded before being read.
  always_ff @(posedge clk) begin
    hold_q  <= hold_d;
    shift_q <= shift_d;
  end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter. It is the stimulus end of the 1011 sequence-detector path: it accepts a parallel word over a valid/ready handshake and shifts it out MSB-first on a single-bit line. The word can be repeated a programmable number of times. A built-in overlapping "1011" occurrence counter reports how many detections a downstream detector must flag for the emitted stream.

Parameters:
WIDTH, 8, word length in bits (WIDTH >= 2)
REP_W, 4, width of repeat-count field
CNT_W, 8, width of the saturating match counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  word offered
in_ready  output  1  block can accept a word (high only in IDLE)
in_data  input  WIDTH  word to transmit, bit WIDTH-1 sent first
in_repeat  input  REP_W  extra transmissions; word sent in_repeat+1 times
x  output  1  serial data bit (0 when x_valid=0)
x_valid  output  1  x carries a stream bit this cycle
busy  output  1  high from acceptance through last bit
done  output  1  one-cycle pulse after the final bit of a transfer
match_cnt  output  CNT_W  overlapping "1011" occurrences emitted since reset/clear
clear_cnt  input  1  synchronous clear of match_cnt and bit history

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Reset (rst=1 at an edge): state IDLE, x=0, x_valid=0, busy=0, done=0, match_cnt=0, 4-bit history=0. Reset overrides everything, including a transfer in progress: that transfer is aborted, x_valid=0 from the next cycle, and no done pulse is generated.
- in_ready is decoded from the state register: in_ready = (state==IDLE). It is not registered separately.
- States: IDLE, SHIFT, and GAP (GAP exists only with the optional feature).
- IDLE to SHIFT on the edge where in_valid && in_ready.
  - At that edge: capture in_data into a hold register and the shift register, and load rep_left = in_repeat and bit_idx = WIDTH-1.
  - Also at that edge, drive x = in_data[WIDTH-1], x_valid=1, busy=1.
  - Latency: the first bit is visible in the cycle immediately after the accepting edge.
- SHIFT: each edge emits the next bit MSB-first; x and x_valid are registered outputs.
  - After the WIDTH-th bit of a word, if rep_left>0: reload the shift register from the hold register, decrement rep_left, and continue with no bubble.
  - After the WIDTH-th bit with rep_left==0: go to IDLE with x=0, x_valid=0, busy=0, done=1 for exactly one cycle.
- Total x_valid-high cycles per transfer = WIDTH*(in_repeat+1), contiguous.
- in_valid while not in IDLE is ignored; in_data and in_repeat changes mid-transfer have no effect.
- Back-to-back transfers: a word can be accepted during the done cycle, since in_ready=1 there. This gives exactly one x_valid=0 cycle between transfers.
- Match counter:
  - A 4-bit history shifts in every emitted bit (only when x_valid is being driven high).
  - When the history plus the new bit equals 1011, match_cnt increments on the same edge the completing bit is driven, so match_cnt includes the bit currently on x.
  - Detection is overlapping. History persists across repeats, across transfers, and across idle cycles.
  - match_cnt saturates at 2^CNT_W-1.
- clear_cnt=1 zeroes match_cnt and the history at the next edge. It wins over a simultaneous increment, and bit emission continues unaffected.
- in_repeat=0 means a single transmission. in_repeat=2^REP_W-1 means 2^REP_W transmissions.

Optional Feature:
Macro: SEQ_TX_GAP_EN.
- Defined: between repeats, insert one GAP cycle with x=0 and x_valid=0. busy stays high and the history is unchanged. x_valid-high cycles remain WIDTH*(in_repeat+1); the transfer spans in_repeat extra cycles.
- Undefined: GAP state and logic are absent, and repeats are contiguous.

Test Plan:
1. Hold rst=1 for 2 cycles mid-stream -> x=0, x_valid=0, busy=0, done=0, match_cnt=0, in_ready=1; no done pulse.
2. in_data=8'b1011_1011, in_repeat=0 -> x=1,0,1,1,1,0,1,1 over 8 consecutive x_valid cycles; done in cycle 9; match_cnt=2.
3. in_data=8'b1100_0010, in_repeat=1 -> 16 contiguous bits (17-cycle span with SEQ_TX_GAP_EN); match_cnt=1, from the cross-repeat match at bits 6-9.
4. Accept a word; pulse in_valid with other data during SHIFT -> ignored. Offer the next word in the done cycle -> accepted, exactly one x_valid=0 bubble between transfers.
5. CNT_W=2, in_data=8'b1011_1011, in_repeat=1 -> 4 matches emitted; match_cnt saturates at 3. Assert clear_cnt on the same edge as a completing '1' -> match_cnt=0.
6. rst asserted on bit 3 of an 8-bit word -> x_valid=0 next cycle, in_ready=1, no done pulse, match_cnt=0.
